// File: rtl/free_space_incrementer_if.sv
// Request/load inputs and count/status outputs of the bit-serial free-space incrementer.
// WIDTH must match the WIDTH of the attached free_space_incrementer.
interface free_space_incrementer_if #(
    parameter int WIDTH = 4
);
    logic             exit_req;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] free_spaces;
    logic             busy;
    logic             done;
    logic             reject;
    logic             full;

    modport master (
        output exit_req, load, load_value,
        input  free_spaces, busy, done, reject, full
    );

    modport slave (
        input  exit_req, load, load_value,
        output free_spaces, busy, done, reject, full
    );
endinterface

// File: rtl/free_space_incrementer.sv
// Bit-serial +1 on the free-space count, LSB first, saturating at CAPACITY; WIDTH clocks per add.
// Optional macro EXIT_QUEUE_EN: one-deep pending flag for exit requests arriving mid-add.
module free_space_incrementer #(
    parameter int WIDTH    = 4,
    parameter int CAPACITY = 10
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    free_space_incrementer_if.slave io_bus
);
    localparam int               IDXW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] CAP  = WIDTH'(CAPACITY);
    localparam logic [IDXW-1:0]  LAST = IDXW'(WIDTH - 1);

    typedef enum logic {IDLE, ADD} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_free;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [IDXW-1:0]  r_index;
    logic             r_done;
    logic             r_reject;

    logic             w_sum;
    logic             w_cout;
    logic             w_full;
    logic             w_req;
    logic [WIDTH-1:0] w_next_result;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_commit;

    // Full-adder cell with b tied to 0: the +1 enters through the initial carry.
    assign w_sum          = r_operand[0] ^ r_carry;
    assign w_cout         = r_operand[0] & r_carry;
    assign w_next_result  = {w_sum, r_result[WIDTH-1:1]};
    assign w_commit       = (w_next_result > CAP) ? CAP : w_next_result;
    assign w_load_clamped = (io_bus.load_value > CAP) ? CAP : io_bus.load_value;
    assign w_full         = (r_free == CAP);

`ifdef EXIT_QUEUE_EN
    logic r_pending;
    assign w_req = io_bus.exit_req | r_pending;
`else
    assign w_req = io_bus.exit_req;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_free    <= '0;
            r_operand <= '0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_index   <= '0;
            r_done    <= 1'b0;
            r_reject  <= 1'b0;
`ifdef EXIT_QUEUE_EN
            r_pending <= 1'b0;
`endif
        end else begin
            r_done   <= 1'b0;
            r_reject <= 1'b0;
            if (io_bus.load) begin
                r_free  <= w_load_clamped;
                r_state <= IDLE;
`ifdef EXIT_QUEUE_EN
                r_pending <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
`ifdef EXIT_QUEUE_EN
                        r_pending <= 1'b0;
`endif
                        if (w_req) begin
                            if (w_full) begin
                                r_reject <= 1'b1;
                            end else begin
                                r_operand <= r_free;
                                r_carry   <= 1'b1;
                                r_index   <= '0;
                                r_state   <= ADD;
                            end
                        end
                    end
                    ADD: begin
`ifdef EXIT_QUEUE_EN
                        if (io_bus.exit_req) r_pending <= 1'b1;
`endif
                        r_result  <= w_next_result;
                        r_carry   <= w_cout;
                        r_operand <= r_operand >> 1;
                        r_index   <= r_index + 1'b1;
                        // Final carry-out is dropped; a full count never starts an add.
                        if (r_index == LAST) begin
                            r_free  <= w_commit;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign io_bus.free_spaces = r_free;
    assign io_bus.busy        = (r_state == ADD);
    assign io_bus.done        = r_done;
    assign io_bus.reject      = r_reject;
    assign io_bus.full        = w_full;
endmodule

// File: doc/free_space_incrementer.md
# free_space_incrementer

Bit-serial incrementer for the lot's free-space count: each accepted car-exit request adds one to the count with a one-bit full-adder cell, one bit per clock, LSB first. It is the count-up counterpart of the decrementing subtractor chain in the counters path. It owns the free-space register, saturates at the lot capacity, and can be reloaded from the entry side or the controller.

## Interface
- WIDTH, 4, width of the free-space count.
- CAPACITY, 10, number of spaces (count ceiling); must satisfy 0 < CAPACITY < 2^WIDTH.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- exit_req  input  1  car left the lot; sampled only in IDLE.
- load  input  1  overwrite the count with load_value; highest priority after reset.
- load_value  input  WIDTH  value for load; clamped to CAPACITY.
- free_spaces  output  WIDTH  registered free-space count.
- busy  output  1  serial add in progress.
- done  output  1  one-cycle pulse: the increment has been committed.
- reject  output  1  one-cycle pulse: exit_req arrived while the count was at CAPACITY.
- full  output  1  combinational; free_spaces == CAPACITY (lot empty).

## Operation
- States:
  - IDLE, ADD.
  - The datapath holds the operand shift register, result shift register, carry flop, and a bit index of ceil(log2(WIDTH+1)) bits.
- Priority per edge: reset, then load, then the state action.
- Reset:
  - free_spaces, busy, done, reject, carry, index and operand all go to 0.
  - State goes to IDLE.
  - full = 0.
- Load, in any state:
  - free_spaces <= min(load_value, CAPACITY).
  - Any in-progress add is aborted with no done; state goes to IDLE.
  - An exit_req in the same cycle is ignored.
- IDLE, exit_req=1, full=0 (accept):
  - Operand <= free_spaces, carry <= 1, index <= 0, state goes to ADD.
- IDLE, exit_req=1, full=1:
  - reject pulses for one cycle; count is unchanged; stay in IDLE.
- ADD, each cycle:
  - The full-adder cell takes a = operand[0], b = 0, carry_in = carry.
  - The sum bit shifts into the result MSB; carry <= carry-out.
  - The operand shifts right; index increments.
- ADD, last bit (index == WIDTH-1):
  - free_spaces <= assembled result, clamped to CAPACITY.
  - done pulses; state goes to IDLE.
  - The final carry-out is discarded. It is unreachable because the full check blocks it.
- exit_req seen while in ADD is handled according to Configuration.
- busy = (state == ADD).

## Timing
- With the accept at edge k:
  - busy is high for the cycles after edges k .. k+WIDTH-1.
  - free_spaces updates and done=1 in the cycle after edge k+WIDTH.
  - Latency is WIDTH clocks.
- done and reject are registered single-cycle pulses. They are never both high.
- Back-to-back: exit_req held high during the done cycle is accepted on that edge, giving one increment per WIDTH+... cycles. The sustained rate is one increment every WIDTH+1 cycles.
- full follows free_spaces combinationally, with no extra latency.
- A load during ADD takes effect at the next edge. busy drops in the following cycle.

## Configuration
- Macro: EXIT_QUEUE_EN.
- Defined:
  - A one-deep pending flag captures any exit_req seen in ADD.
  - In the done cycle, IDLE treats a set pending flag as exit_req and clears it. The accept or reject decision uses the committed count.
  - A second request while the flag is already set is lost.
  - Load and reset clear the flag.
- Undefined:
  - exit_req in ADD is ignored with no indication.
  - No pending logic is synthesized.

## Test plan
- Reset, then a 5-cycle idle period -> free_spaces=0, full=0, busy/done/reject=0 throughout.
- load=1, load_value=7, then one exit_req pulse -> busy for 4 cycles, done in the 5th cycle after accept, free_spaces=8.
- load_value=15 -> free_spaces=10, full=1. Then exit_req -> reject pulse next cycle, count stays 10, busy never rises.
- load 3, exit_req, then load 5 asserted on the 2nd ADD cycle -> no done, free_spaces=5, busy low afterwards.
- load 9, exit_req held high for 12 cycles:
  - First add commits 10 (done).
  - The next accept sees full and pulses reject.
  - The count never exceeds 10.
- EXIT_QUEUE_EN defined: load 2, exit_req at accept plus one pulse during ADD -> two done pulses 5 cycles apart, final free_spaces=4. With the macro undefined, the same stimulus gives one done and free_spaces=3.
